// File: rtl/clk_mode_detector_pkg.sv
// Shared types and helpers for the clock-mode detector: FSM states, mode width,
// and the nominal-period / tolerance window of each power-of-two mode.
package clk_mode_pkg;

    localparam int NUM_MODES = 8;
    localparam int MODE_W    = 3;

    typedef logic [MODE_W-1:0] mode_t;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        CONFIRM,
        LOCKED
    } state_t;

    // Window arithmetic is done at 64 bits so no parameter choice can overflow it.
    typedef logic [63:0] wide_t;

    typedef struct packed {
        wide_t nominal;
        wide_t tol;
    } mode_win_t;

    function automatic mode_win_t mode_window(input wide_t       base,
                                              input int unsigned tol_shift,
                                              input int unsigned k);
        mode_win_t w;
        w.nominal = base << k;
        w.tol     = w.nominal >> tol_shift;
        return w;
    endfunction

endpackage

// File: rtl/clk_mode_detector_if.sv
// Signal bundle between the clock-mode detector (master) and its consumer (slave).
interface clk_mode_detector_if;
    import clk_mode_pkg::*;

    logic  din;
    mode_t expected;
    mode_t mode_out;
    logic  valid;
    logic  mode_chg;
    logic  timeout;
    logic  mismatch;

    modport master (
        input  din, expected,
        output mode_out, valid, mode_chg, timeout, mismatch
    );

    modport slave (
        output din, expected,
        input  mode_out, valid, mode_chg, timeout, mismatch
    );

endinterface

// File: rtl/clk_mode_detector_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse; the pulse appears 3 clk cycles after the input rises.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // pre-edge value of the one before it; blocking would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/clk_mode_detector.sv
// Measures the period of a divided clock and decodes its power-of-two mode,
// locking after two consecutive matching periods. Optional EXPECT_CHECK_EN
// compares the locked mode against the generator's claimed mode.
module clk_mode_detector
    import clk_mode_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 10000000,
    parameter int unsigned TOL_SHIFT   = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    clk_mode_detector_if.master        m_if
);

    localparam wide_t              N_MAX = wide_t'(BASE_PERIOD) << (NUM_MODES - 1);
    localparam logic [CNT_W-1:0]   TMAX  = CNT_W'(N_MAX + (N_MAX >> TOL_SHIFT) + 64'd1);

    logic w_rise;

    sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_din  (m_if.din),
        .o_rise (w_rise)
    );

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    mode_t            r_cand,     w_cand_nxt;
    mode_t            r_mode_out, w_mode_nxt;
    logic             r_valid,    w_valid_nxt;
    logic             r_mode_chg, w_chg_nxt;
    logic             r_timeout,  w_timeout_nxt;

    logic [CNT_W:0] w_period;
    wide_t          w_period_wide;
    mode_win_t      w_win;
    logic           w_match;
    mode_t          w_match_mode;
    logic           w_sat;

    // Classifier: windows never overlap, so at most one mode can match.
    always_comb begin
        w_period      = (CNT_W+1)'(r_cnt) + 1'b1;
        w_period_wide = wide_t'(w_period);
        w_win         = '0;
        w_match       = 1'b0;
        w_match_mode  = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            w_win = mode_window(wide_t'(BASE_PERIOD), TOL_SHIFT, k);
            if (w_period_wide >= w_win.nominal - w_win.tol &&
                w_period_wide <= w_win.nominal + w_win.tol) begin
                w_match      = 1'b1;
                w_match_mode = mode_t'(k);
            end
        end
    end

    assign w_sat = (r_cnt == TMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_cnt      <= '0;
            r_cand     <= '0;
            r_mode_out <= '0;
            r_valid    <= 1'b0;
            r_mode_chg <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cand     <= w_cand_nxt;
            r_mode_out <= w_mode_nxt;
            r_valid    <= w_valid_nxt;
            r_mode_chg <= w_chg_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_sat ? r_cnt : r_cnt + 1'b1;
        w_cand_nxt    = r_cand;
        w_mode_nxt    = r_mode_out;
        w_valid_nxt   = r_valid;
        w_chg_nxt     = 1'b0;
        w_timeout_nxt = r_timeout;

        if (w_rise) begin
            w_cnt_nxt = '0;
            unique case (r_state)
                SEARCH: w_state_nxt = MEASURE;
                MEASURE: begin
                    if (w_match) begin
                        w_cand_nxt  = w_match_mode;
                        w_state_nxt = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!w_match) begin
                        w_state_nxt = MEASURE;
                    end else if (w_match_mode == r_cand) begin
                        w_state_nxt   = LOCKED;
                        w_mode_nxt    = r_cand;
                        w_valid_nxt   = 1'b1;
                        w_chg_nxt     = 1'b1;
                        w_timeout_nxt = 1'b0;
                    end else begin
                        w_cand_nxt = w_match_mode;
                    end
                end
                LOCKED: begin
                    // mode_out keeps the last locked value until a new lock.
                    if (!w_match) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = MEASURE;
                    end else if (w_match_mode != r_mode_out) begin
                        w_valid_nxt = 1'b0;
                        w_cand_nxt  = w_match_mode;
                        w_state_nxt = CONFIRM;
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end else if (w_sat && r_state != SEARCH) begin
            w_state_nxt   = SEARCH;
            w_valid_nxt   = 1'b0;
            w_timeout_nxt = 1'b1;
        end
    end

    assign m_if.mode_out = r_mode_out;
    assign m_if.valid    = r_valid;
    assign m_if.mode_chg = r_mode_chg;
    assign m_if.timeout  = r_timeout;

`ifdef EXPECT_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= r_valid && (r_mode_out != m_if.expected);
        end
    end

    assign m_if.mismatch = r_mismatch;
`else
    logic w_unused_expected;

    assign w_unused_expected = ^m_if.expected;
    assign m_if.mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_clk_mode_detector.sv
// Scoreboard bench for clk_mode_detector: stimulus queues expected lock/drop/
// timeout events, a negedge monitor pops and compares them as they appear.
module tb_clk_mode_detector;
    import clk_mode_pkg::*;

    localparam int BASE  = 16;
    localparam int TOLS  = 3;
    localparam int TMAX  = 2305;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_mode_detector_if dut_if ();

    clk_mode_detector #(
        .BASE_PERIOD (BASE),
        .TOL_SHIFT   (TOLS),
        .CNT_W       (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .m_if (dut_if.master)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_LOCK, EV_DROP, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       mode;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push(input ev_kind_t kind, input int mode);
        ev_t e;
        e.kind = kind;
        e.mode = mode;
        sb.push_back(e);
    endtask

    // One period: rising edge now, high for p/2, low for the rest.
    task automatic period(input int p);
        dut_if.din = 1'b1;
        repeat (p / 2) @(negedge clk);
        dut_if.din = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    // Monitor
    logic  prev_valid   = 1'b0;
    logic  prev_timeout = 1'b0;
    logic  prev_chg     = 1'b0;
    ev_t   ev;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid   = 1'b0;
            prev_timeout = 1'b0;
            prev_chg     = 1'b0;
        end else begin
            if (dut_if.mode_chg) begin
                check("mode_chg_single", prev_chg, 0);
                check("sb_has_lock", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    check("lock_kind", ev.kind, EV_LOCK);
                    check("lock_mode", dut_if.mode_out, ev.mode);
                    check("lock_valid", dut_if.valid, 1);
                    check("lock_timeout", dut_if.timeout, 0);
                end
            end else if (dut_if.timeout && !prev_timeout) begin
                check("sb_has_timeout", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    check("timeout_kind", ev.kind, EV_TIMEOUT);
                    check("timeout_valid", dut_if.valid, 0);
                end
            end else if (prev_valid && !dut_if.valid) begin
                check("sb_has_drop", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    check("drop_kind", ev.kind, EV_DROP);
                    check("drop_mode_held", dut_if.mode_out, ev.mode);
                end
            end
            prev_valid   = dut_if.valid;
            prev_timeout = dut_if.timeout;
            prev_chg     = dut_if.mode_chg;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mode_out"}, dut_if.mode_out, 0);
        check({tag, "_valid"},    dut_if.valid,    0);
        check({tag, "_mode_chg"}, dut_if.mode_chg, 0);
        check({tag, "_timeout"},  dut_if.timeout,  0);
        check({tag, "_mismatch"}, dut_if.mismatch, 0);
    endtask

    initial begin
        int n;
        dut_if.din      = 1'b0;
        dut_if.expected = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_state", dut.r_state, SEARCH);
        rst = 1'b0;
        @(negedge clk);

        // Period 128 locks mode 3 on the third rising edge.
        push(EV_LOCK, 3);
        repeat (3) period(128);

        // Switch to 32: drop after one period, relock on mode 1 after the next.
        push(EV_DROP, 3);
        push(EV_LOCK, 1);
        repeat (3) period(32);

        // 16, 40 (no match), 16, 16: lock to mode 0 only after the last pair.
        push(EV_DROP, 1);
        push(EV_LOCK, 0);
        period(16);
        period(40);
        period(16);
        period(16);
        period(16);

        // Hold din low: timeout TMAX+5 negedges after the last din rise.
        push(EV_TIMEOUT, 0);
        n = 16;
        while (!dut_if.timeout && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TMAX + 5);
        check("timeout_state", dut.r_state, SEARCH);

        // Restart at 16: first edge ignored, timeout clears on relock.
        push(EV_LOCK, 0);
        period(16);
        check("timeout_sticky", dut_if.timeout, 1);
        period(16);
        period(16);

        // Tolerance edges of mode 7, then one cycle beyond.
        push(EV_DROP, 0);
        push(EV_LOCK, 7);
        push(EV_DROP, 7);
        period(2048 + 256);
        period(2048 - 256);
        period(2048 + 257);

        // Lock on mode 2.
        push(EV_LOCK, 2);
        repeat (3) period(64);
        check("locked_mode2_valid", dut_if.valid, 1);

`ifdef EXPECT_CHECK_EN
        dut_if.expected = 3'd5;
        repeat (2) @(negedge clk);
        check("mismatch_exp5", dut_if.mismatch, 1);
        dut_if.expected = 3'd2;
        repeat (2) @(negedge clk);
        check("mismatch_exp2", dut_if.mismatch, 0);
        dut_if.expected = 3'd5;
        repeat (2) @(negedge clk);
`else
        dut_if.expected = 3'd5;
        repeat (2) @(negedge clk);
        check("mismatch_tied", dut_if.mismatch, 0);
`endif

        // Asynchronous reset mid-LOCKED clears outputs without a clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        dut_if.expected = '0;
        @(negedge clk);

        // History discarded: two edges are not enough, the third locks.
        push(EV_LOCK, 2);
        repeat (2) period(64);
        check("post_reset_no_early_lock", dut_if.valid, 0);
        period(64);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
